// File: rtl/pls_nios2_gen2_0_cpu_ocimem_arb.sv
// Arbiter between the JTAG debug path and the CPU for the shared OCI debug RAM.
// Single-cycle RAM access per grant; read data returns in a following RD_WAIT cycle.
module pls_nios2_gen2_0_cpu_ocimem_arb #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] JTAG_ACC = 2'd1;
  localparam logic [1:0] CPU_ACC  = 2'd2;
  localparam logic [1:0] RD_WAIT  = 2'd3;

  localparam logic GNT_JTAG = 1'b0;
  localparam logic GNT_CPU  = 1'b1;

  logic [1:0]        state;
  logic              pending;
  logic              pend_we;
  logic              rd_jtag;
  logic              last_gnt;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0]       jtag_wdata;

  logic cmd_any, jtag_done, accept;
  logic post_wr, post_rd, post_new;
  logic jtag_req, gnt_jtag, gnt_cpu;
  logic jdo_unused;

  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  assign cmd_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jtag_done = ((state == JTAG_ACC) && pend_we) || ((state == RD_WAIT) && rd_jtag);
  // A command arriving in the completion cycle replaces the finishing one instead of overrunning it.
  assign accept    = cmd_any && (!pending || jtag_done);
  assign post_wr   = accept && take_action_ocimem_b;
  assign post_rd   = accept && !take_action_ocimem_b &&
                     ((take_action_ocimem_a && jdo[34]) || take_no_action_ocimem_a);
  assign post_new  = post_wr | post_rd;

  // A command posted while idle is arbitrated immediately; its address/data land on the same edge.
  assign jtag_req = pending || post_new;
  assign gnt_jtag = jtag_req && (!cpu_req || (last_gnt == GNT_CPU));
  assign gnt_cpu  = cpu_req && !gnt_jtag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      pend_we       <= 1'b0;
      rd_jtag       <= 1'b0;
      last_gnt      <= GNT_CPU;
      jtag_addr     <= '0;
      jtag_wdata    <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_jtag) begin
            state    <= JTAG_ACC;
            last_gnt <= GNT_JTAG;
          end else if (gnt_cpu) begin
            state    <= CPU_ACC;
            last_gnt <= GNT_CPU;
          end
        end
        JTAG_ACC: begin
          if (pend_we) begin
            state <= IDLE;
          end else begin
            state   <= RD_WAIT;
            rd_jtag <= 1'b1;
          end
        end
        CPU_ACC: begin
          if (cpu_we) begin
            state <= IDLE;
          end else begin
            state   <= RD_WAIT;
            rd_jtag <= 1'b0;
          end
        end
        RD_WAIT: begin
          state <= IDLE;
          if (rd_jtag) MonDReg <= ram_rdata;
        end
        default: state <= IDLE;
      endcase

      if (post_new) begin
        pending <= 1'b1;
        pend_we <= post_wr;
      end else if (jtag_done) begin
        pending <= 1'b0;
      end

      if (post_wr) jtag_wdata <= jdo[34:3];

      if (accept && take_action_ocimem_a) begin
        jtag_addr <= jdo[ADDR_W+16:17];
      end else if (jtag_done) begin
        jtag_addr <= jtag_addr + ADDR_W'(1);
      end

      if (cmd_any && !accept) begin
        monitor_error <= 1'b1;
      end else if (accept && take_action_ocimem_a) begin
        monitor_error <= 1'b0;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      JTAG_ACC: begin
        ram_addr  = jtag_addr;
        ram_we    = pend_we;
        ram_re    = !pend_we;
        ram_wdata = pend_we ? jtag_wdata : '0;
      end
      CPU_ACC: begin
        ram_addr  = cpu_addr;
        ram_we    = cpu_we;
        ram_re    = !cpu_we;
        ram_wdata = cpu_we ? cpu_wdata : '0;
      end
      default: ;
    endcase
  end

  assign cpu_gnt       = (state == CPU_ACC);
  assign cpu_rvalid    = (state == RD_WAIT) && !rd_jtag;
  assign cpu_rdata     = cpu_rvalid ? ram_rdata : '0;
  assign monitor_ready = !pending;

endmodule

// File: doc/pls_nios2_gen2_0_cpu_ocimem_arb.md
PLS_NIOS2_GEN2_0_CPU_OCIMEM_ARB -- requirements
Module: pls_nios2_gen2_0_cpu_ocimem_arb

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width of the shared debug RAM.
REQ-002 clk  in  1: sole clock; every register is clocked on the rising edge.
REQ-003 reset  in  1: asynchronous, active-high reset.
REQ-004 jdo  in  38: JTAG data word from the debug-slave sysclk stage, used as fields [ADDR_W+16:17] = addr, [34] = read-on-load, [34:3] = write data.
REQ-005 take_action_ocimem_a  in  1: one-cycle pulse; load the JTAG address.
REQ-006 take_action_ocimem_b  in  1: one-cycle pulse; JTAG write request.
REQ-007 take_no_action_ocimem_a  in  1: one-cycle pulse; JTAG read-next request.
REQ-008 cpu_req / cpu_we  in  1 / 1: CPU access request (level) / write qualifier.
REQ-009 cpu_addr / cpu_wdata  in  ADDR_W / 32: CPU address / CPU write data, held stable while cpu_req=1.
REQ-010 cpu_gnt / cpu_rvalid  out  1 / 1: grant pulse / read-data-valid pulse.
REQ-011 cpu_rdata  out  32: CPU read data.
REQ-012 ram_addr / ram_wdata  out  ADDR_W / 32: RAM address / RAM write data.
REQ-013 ram_we / ram_re  out  1 / 1: RAM write strobe / RAM read strobe.
REQ-014 ram_rdata  in  32: RAM read data, valid exactly 1 cycle after ram_re.
REQ-015 MonDReg  out  32: last JTAG read data.
REQ-016 monitor_ready / monitor_error  out  1 / 1: JTAG path idle / sticky JTAG overrun flag.

Function
REQ-017 The block SHALL implement FSM states IDLE, JTAG_ACC, CPU_ACC and RD_WAIT.
REQ-018 take_action_ocimem_a SHALL load jtag_addr from jdo[ADDR_W+16:17], clear monitor_error, and, when jdo[34]=1, post a pending JTAG read.
REQ-019 take_action_ocimem_b SHALL post a pending JTAG write of jdo[34:3] to jtag_addr.
REQ-020 take_no_action_ocimem_a SHALL post a pending JTAG read of jtag_addr.
REQ-021 Posting any JTAG command SHALL clear monitor_ready in the following cycle.
REQ-022 Only one JTAG command SHALL be pending; a command posted while one is pending SHALL be dropped and SHALL set monitor_error, leaving the pending command unchanged.
REQ-023 In IDLE, when only one side is pending, the block SHALL grant that side.
REQ-024 In IDLE, when both sides are pending, the block SHALL grant the side not granted last (round-robin, last_gnt register); JTAG SHALL win after reset.
REQ-025 JTAG_ACC and CPU_ACC SHALL each last one cycle, driving ram_addr with ram_we or ram_re for exactly that cycle.
REQ-026 cpu_gnt SHALL pulse in the CPU_ACC cycle.
REQ-027 A write access SHALL return to IDLE; a read access SHALL enter RD_WAIT for one cycle.
REQ-028 In RD_WAIT, a JTAG read SHALL capture ram_rdata into MonDReg; a CPU read SHALL drive cpu_rdata = ram_rdata with cpu_rvalid=1 for that one cycle.
REQ-029 Completion of a JTAG access (write cycle, or RD_WAIT for a read) SHALL set monitor_ready=1 in the following cycle, increment jtag_addr modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8) and clear the pending flag.
REQ-030 A JTAG command posted in the same cycle as completion of the previous one SHALL be accepted, not flagged as an error.
REQ-031 Back-to-back service SHALL be possible: IDLE is re-entered and arbitrated on the cycle after a write access or RD_WAIT.
REQ-032 The CPU side SHALL keep cpu_req asserted until it sees cpu_gnt; the block SHALL NOT grant a deasserted request.

Reset
REQ-033 On reset the block SHALL set: state=IDLE; monitor_ready=1; monitor_error=0; MonDReg=0; jtag_addr=0; pending=0; last_gnt=CPU; cpu_gnt, cpu_rvalid, ram_we and ram_re = 0; cpu_rdata, ram_addr and ram_wdata = 0.
REQ-034 Reset asserted mid-access SHALL abort the access with no RAM strobe after assertion; the lost command SHALL NOT be replayed.

Verification
REQ-035 Scenario: ocimem_a with addr=0x10, jdo[34]=1; RAM[0x10]=0xDEADBEEF -> ram_re at addr 0x10, MonDReg=0xDEADBEEF, monitor_ready=1, jtag_addr=0x11.
REQ-036 Scenario: ocimem_b with data 0x12345678 at jtag_addr=0xFF -> ram_we at 0xFF with that data; jtag_addr wraps to 0x00.
REQ-037 Scenario: cpu_req read and JTAG read pending together, starting from reset -> JTAG served first, then CPU; cpu_rvalid one cycle after cpu_gnt.
REQ-038 Scenario: second ocimem_b posted while the first is pending -> monitor_error=1 and only one write occurs; next ocimem_a clears monitor_error.
REQ-039 Scenario: continuous cpu_req and a continuous JTAG command stream -> grants alternate JTAG/CPU with no idle gap beyond RD_WAIT.
REQ-040 Scenario: reset asserted in RD_WAIT -> no cpu_rvalid, monitor_ready=1, all outputs at the REQ-033 reset values.
